reg_bank_arbiter: RTL and testbench
===================================

// Module: reg_bank_arbiter
// PURPOSE
//  Controller and arbiter for a bank of NUM_REGS x DATA_W enable/clear registers.
//  Two requesters (A, B) share the single write port of the bank:
//   - a round-robin arbiter selects one requester;
//   - an FSM sequences the write or clear and completes a 4-phase req/ack handshake.
//  Sits between control logic and the register bank; the read port is always available.
// PARAMETERS
//  DATA_W    8  width of each bank register
//  NUM_REGS  4  number of registers in the bank (1..2**ADDR_W)
//  ADDR_W    2  width of the register address
// PORTS
//  clk       in   1       system clock, rising edge
//  reset     in   1       asynchronous, active-low reset
//  req_a     in   1       requester A write request (level, 4-phase)
//  clr_a     in   1       A: 1 = clear register to 0, 0 = write data_a
//  addr_a    in   ADDR_W  A: target register
//  data_a    in   DATA_W  A: write data
//  gnt_a     out  1       A owns the bank (registered)
//  ack_a     out  1       A: write committed (registered)
//  req_b/clr_b/addr_b/data_b/gnt_b/ack_b   same as A, for requester B
//  rd_addr   in   ADDR_W  read address
//  rd_data   out  DATA_W  bank[rd_addr], combinational; 0 if rd_addr >= NUM_REGS
//  busy      out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (reset=0, async)
//   - all bank regs = 0; gnt_*, ack_*, busy = 0; state = IDLE; rr_ptr = A (A preferred).
//  FSM states: IDLE, WRITE, WAIT.
//  IDLE
//   - If any req at the edge:
//       only one req -> that requester wins;
//       both reqs -> winner = rr_ptr.
//   - On the edge:
//       latch winner's clr/addr/data;
//       gnt_winner <= 1;
//       rr_ptr <= the other requester;
//       state -> WRITE.
//   - With no req, stay in IDLE.
//  WRITE (exactly 1 cycle)
//   - On the edge: bank[addr] <= clr ? 0 : data; ack_winner <= 1; state -> WAIT.
//   - The write uses the latched values; input changes after the grant edge are ignored.
//  WAIT
//   - ack and gnt stay high while the winner's req = 1.
//   - When the winner's req = 0 at an edge: ack and gnt <= 0; state -> IDLE.
//   - The loser's req is ignored until IDLE.
//  Latency
//   - req seen at edge N -> gnt at N -> bank updated and ack at N+1.
//   - req low seen at edge M -> ack/gnt low at M -> next grant possible at M+1.
//   - Minimum turnaround is 3 cycles per transaction.
//  Boundary conditions
//   - addr >= NUM_REGS: no register is written, but the handshake completes normally (ack still given).
//   - Winner drops req during WRITE: the write still commits; ack is high for 1 cycle
//     (in WAIT, req low seen -> IDLE).
//   - Both reqs held continuously: grants alternate A, B, A, ... with no starvation.
//   - Reset mid-transaction:
//       the pending write is lost if reset occurs before the WRITE edge;
//       bank is cleared and all outputs drop immediately.
//   - Requester must not raise req again until it has seen its ack low (4-phase rule).
//     The arbiter re-arbitrates from IDLE whenever req is high.
//   - Bank registers hold their value when not written; rd_data reflects the new value
//     the cycle after the WRITE edge.
// TESTING
//  1 Reset: drive reset=0 mid-sim with the bank loaded
//    -> all rd_data=0, gnt/ack/busy=0 immediately (async).
//  2 Single write: A req, addr=2, data=8'h81
//    -> gnt_a at next edge, ack_a one edge later, rd_addr=2 gives 8'h81;
//    drop req_a -> ack_a/gnt_a low next edge.
//  3 Contention: A and B req in the same cycle from reset
//    -> A granted first; B granted after A's handshake;
//    repeat both -> B granted first (round-robin).
//  4 Clear: reg1=8'hFF, B req with clr_b=1, addr=1, data_b=8'hAA
//    -> reg1 becomes 8'h00 (data ignored).
//  5 Out of range: NUM_REGS=3, A writes addr=3, data=8'h55
//    -> ack_a asserted, no bank change, rd_data(addr 3)=0.
//  6 Reset during WRITE: assert reset after gnt_a, before the WRITE edge
//    -> no write, state IDLE, rr_ptr=A after release.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// Module      : reg_bank_arbiter
// Description : Two-requester round-robin arbiter and 4-phase write sequencer
//               in front of a NUM_REGS x DATA_W register bank.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_bank_arbiter #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              clr_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              gnt_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic              clr_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_b,
    output logic              ack_b,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_rr_b;      // 1 = B preferred on contention
    logic                r_owner_b;
    logic                r_clr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_gnt_a;
    logic                r_gnt_b;
    logic                r_ack_a;
    logic                r_ack_b;
    logic [DATA_W-1:0]   r_bank [NUM_REGS];

    logic                w_pick_b;
    logic                w_owner_req;
    logic                w_commit;
    logic [DATA_W-1:0]   w_wr_val;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_pick_b    = req_b & (~req_a | r_rr_b);
    assign w_owner_req = r_owner_b ? req_b : req_a;
    assign w_commit    = (r_state == WRITE);
    assign w_wr_val    = r_clr ? '0 : r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_rr_b    <= 1'b0;
            r_owner_b <= 1'b0;
            r_clr     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_gnt_a   <= 1'b0;
            r_gnt_b   <= 1'b0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_a || req_b) begin
                        r_owner_b <= w_pick_b;
                        r_rr_b    <= ~w_pick_b;
                        r_clr     <= w_pick_b ? clr_b  : clr_a;
                        r_addr    <= w_pick_b ? addr_b : addr_a;
                        r_data    <= w_pick_b ? data_b : data_a;
                        r_gnt_a   <= ~w_pick_b;
                        r_gnt_b   <= w_pick_b;
                        r_state   <= WRITE;
                    end
                end
                WRITE: begin
                    r_ack_a <= ~r_owner_b;
                    r_ack_b <= r_owner_b;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!w_owner_req) begin
                        r_gnt_a <= 1'b0;
                        r_gnt_b <= 1'b0;
                        r_ack_a <= 1'b0;
                        r_ack_b <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Out-of-range addresses match no slice, so the write is silently dropped.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_bank[i] <= '0;
                end else if (w_commit && (r_addr == ADDR_W'(i))) begin
                    r_bank[i] <= w_wr_val;
                end
            end
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                w_rd_data = r_bank[i];
            end
        end
    end

    assign rd_data = w_rd_data;
    assign gnt_a   = r_gnt_a;
    assign gnt_b   = r_gnt_b;
    assign ack_a   = r_ack_a;
    assign ack_b   = r_ack_b;
    assign busy    = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
// Module      : tb_reg_bank_arbiter
// Description : Directed bench for reg_bank_arbiter with a transaction-level
//               reference model compared every cycle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reg_bank_arbiter;

    localparam int DW = 8;
    localparam int NR = 3;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_a = 1'b0, clr_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [DW-1:0] data_a = '0;
    logic          req_b = 1'b0, clr_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] data_b = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          gnt_a, ack_a, gnt_b, ack_b, busy;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .clr_a(clr_a), .addr_a(addr_a), .data_a(data_a),
        .gnt_a(gnt_a), .ack_a(ack_a),
        .req_b(req_b), .clr_b(clr_b), .addr_b(addr_b), .data_b(data_b),
        .gnt_b(gnt_b), .ack_b(ack_b),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: owner (-1 none, 0 A, 1 B), whether the commit has happened,
    // the value it will commit, and the round-robin preference.
    int          m_owner;
    bit          m_acked;
    bit          m_pref_b;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_val;
    logic [DW-1:0] m_bank [NR];
    wire         m_pick_b = req_b && (!req_a || m_pref_b);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner  <= -1;
            m_acked  <= 1'b0;
            m_pref_b <= 1'b0;
            for (int i = 0; i < NR; i++) m_bank[i] <= '0;
        end else if (m_owner < 0) begin
            if (req_a || req_b) begin
                m_owner  <= m_pick_b ? 1 : 0;
                m_acked  <= 1'b0;
                m_pref_b <= !m_pick_b;
                m_addr   <= m_pick_b ? addr_b : addr_a;
                m_val    <= m_pick_b ? (clr_b ? 8'h00 : data_b) : (clr_a ? 8'h00 : data_a);
            end
        end else if (!m_acked) begin
            if (int'(m_addr) < NR) m_bank[m_addr] <= m_val;
            m_acked <= 1'b1;
        end else if (!((m_owner == 1) ? req_b : req_a)) begin
            m_owner <= -1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("gnt_a",   gnt_a, m_owner == 0);
            chk("gnt_b",   gnt_b, m_owner == 1);
            chk("ack_a",   ack_a, (m_owner == 0) && m_acked);
            chk("ack_b",   ack_b, (m_owner == 1) && m_acked);
            chk("busy",    busy,  m_owner >= 0);
            chk("rd_data", rd_data, (int'(rd_addr) < NR) ? m_bank[rd_addr] : 8'h00);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit b, input bit r, input bit c, input logic [AW-1:0] ad,
                         input logic [DW-1:0] d);
        if (b) begin req_b = r; clr_b = c; addr_b = ad; data_b = d; end
        else   begin req_a = r; clr_a = c; addr_a = ad; data_a = d; end
    endtask

    task automatic handshake(input bit b, input bit c, input logic [AW-1:0] ad,
                             input logic [DW-1:0] d);
        drive(b, 1'b1, c, ad, d);
        step(2);
        chk(b ? "hs_ack_b" : "hs_ack_a", b ? ack_b : ack_a, 1);
        drive(b, 1'b0, c, ad, d);
        step(1);
        chk("hs_idle", busy, 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gnt",  {gnt_a, gnt_b, ack_a, ack_b}, 0);
        step(2);
        reset = 1'b1;
        step(1);

        // Single write
        rd_addr = 2;
        drive(0, 1, 0, 2, 8'h81);
        step(1);
        chk("sw_gnt_a", gnt_a, 1);
        chk("sw_ack_a0", ack_a, 0);
        step(1);
        chk("sw_ack_a1", ack_a, 1);
        chk("sw_rd", rd_data, 8'h81);
        drive(0, 0, 0, 2, 8'h81);
        step(1);
        chk("sw_drop", {gnt_a, ack_a, busy}, 0);

        // Async reset with bank loaded
        reset = 1'b0;
        #1;
        chk("ar_rd", rd_data, 8'h00);
        chk("ar_out", {gnt_a, gnt_b, ack_a, ack_b, busy}, 0);
        step(1);
        reset = 1'b1;
        step(1);

        // Contention from reset, then round-robin hand-over
        drive(0, 1, 0, 0, 8'h11);
        drive(1, 1, 0, 1, 8'h22);
        step(1);
        chk("ct_first_a", {gnt_a, gnt_b}, 2'b10);
        step(1);
        drive(0, 0, 0, 0, 8'h11);
        step(1);
        drive(0, 1, 0, 2, 8'h33);
        step(1);
        chk("ct_rr_b", {gnt_a, gnt_b}, 2'b01);
        step(1);
        drive(1, 0, 0, 1, 8'h22);
        step(2);
        chk("ct_then_a", {gnt_a, gnt_b}, 2'b10);
        step(1);
        drive(0, 0, 0, 2, 8'h33);
        step(1);
        rd_addr = 0; #1 chk("ct_r0", rd_data, 8'h11);
        rd_addr = 1; #1 chk("ct_r1", rd_data, 8'h22);
        rd_addr = 2; #1 chk("ct_r2", rd_data, 8'h33);

        // Clear ignores data
        handshake(0, 0, 1, 8'hFF);
        rd_addr = 1; #1 chk("cl_pre", rd_data, 8'hFF);
        handshake(1, 1, 1, 8'hAA);
        chk("cl_post", rd_data, 8'h00);

        // Out of range address
        handshake(0, 0, 3, 8'h55);
        rd_addr = 3; #1 chk("oor_rd", rd_data, 8'h00);
        rd_addr = 2; #1 chk("oor_keep", rd_data, 8'h33);

        // Requester drops req during WRITE
        rd_addr = 0;
        drive(0, 1, 0, 0, 8'h5A);
        step(1);
        drive(0, 0, 0, 0, 8'h00);
        step(1);
        chk("dw_ack", ack_a, 1);
        step(1);
        chk("dw_done", {ack_a, gnt_a, busy}, 0);
        chk("dw_rd", rd_data, 8'h5A);

        // Reset between grant and WRITE edge: write lost, preference back to A
        drive(1, 1, 0, 2, 8'h01);
        step(1);
        drive(1, 0, 0, 2, 8'h01);
        step(2);
        drive(0, 1, 0, 0, 8'h77);
        step(1);
        chk("rw_gnt", gnt_a, 1);
        reset = 1'b0;
        #1;
        chk("rw_out", {gnt_a, ack_a, busy}, 0);
        drive(0, 0, 0, 0, 8'h77);
        step(1);
        reset = 1'b1;
        step(1);
        chk("rw_lost", rd_data, 8'h00);
        drive(0, 1, 0, 1, 8'h66);
        drive(1, 1, 0, 2, 8'h99);
        step(1);
        chk("rw_pref_a", {gnt_a, gnt_b}, 2'b10);
        step(1);
        drive(0, 0, 0, 1, 8'h66);
        step(2);
        chk("rw_then_b", gnt_b, 1);
        step(1);
        drive(1, 0, 0, 2, 8'h99);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
